// File: rtl/acca_mul_pipe.sv
// Three-stage quadrant-split approximate multiplier with valid/ready streams.
// Define ACCA_ERR_STAT_EN to count results that differ from the exact product.
module acca_mul_pipe #(
  parameter int         WIDTH       = 8,
  parameter int         TRUNC       = 2,
  parameter logic [3:0] APPROX_MASK = 4'b1111
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 approx_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_prod,
  output logic [15:0]          err_cnt
);

  localparam int H  = WIDTH / 2;
  localparam int PW = 2 * WIDTH;
  localparam logic [WIDTH-1:0] KEEP_MASK = {WIDTH{1'b1}} << TRUNC;

  logic              stall;
  logic              en;
  logic              v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [WIDTH-1:0]  a1_q, a1_d, b1_q, b1_d;
  logic [3:0]        m1_q, m1_d;
  logic [WIDTH-1:0]  p_ll_q, p_ll_d, p_lh_q, p_lh_d, p_hl_q, p_hl_d, p_hh_q, p_hh_d;
  logic [PW-1:0]     prod_q, prod_d;

  // H x H sub-product, widened to 2H bits, low TRUNC bits dropped when approximate
  function automatic logic [WIDTH-1:0] sub_mul(input logic [H-1:0] x,
                                               input logic [H-1:0] y,
                                               input logic         approx);
    logic [WIDTH-1:0] p;
    p = {{H{1'b0}}, x} * {{H{1'b0}}, y};
    if (approx) p = p & KEEP_MASK;
    return p;
  endfunction

  always_comb begin
    stall  = v3_q && !out_ready;
    en     = !stall;
    v1_d   = v1_q;
    a1_d   = a1_q;
    b1_d   = b1_q;
    m1_d   = m1_q;
    v2_d   = v2_q;
    p_ll_d = p_ll_q;
    p_lh_d = p_lh_q;
    p_hl_d = p_hl_q;
    p_hh_d = p_hh_q;
    v3_d   = v3_q;
    prod_d = prod_q;
    if (en) begin
      v1_d   = in_valid;
      a1_d   = in_a;
      b1_d   = in_b;
      m1_d   = approx_en ? APPROX_MASK : 4'b0000;
      v2_d   = v1_q;
      p_ll_d = sub_mul(a1_q[H-1:0],     b1_q[H-1:0],     m1_q[0]);
      p_lh_d = sub_mul(a1_q[H-1:0],     b1_q[WIDTH-1:H], m1_q[1]);
      p_hl_d = sub_mul(a1_q[WIDTH-1:H], b1_q[H-1:0],     m1_q[2]);
      p_hh_d = sub_mul(a1_q[WIDTH-1:H], b1_q[WIDTH-1:H], m1_q[3]);
      v3_d   = v2_q;
      prod_d = {{WIDTH{1'b0}}, p_ll_q}
             + (({{WIDTH{1'b0}}, p_lh_q} + {{WIDTH{1'b0}}, p_hl_q}) << H)
             + {p_hh_q, {WIDTH{1'b0}}};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      a1_q   <= '0;
      b1_q   <= '0;
      m1_q   <= '0;
      v2_q   <= 1'b0;
      p_ll_q <= '0;
      p_lh_q <= '0;
      p_hl_q <= '0;
      p_hh_q <= '0;
      v3_q   <= 1'b0;
      prod_q <= '0;
    end else begin
      v1_q   <= v1_d;
      a1_q   <= a1_d;
      b1_q   <= b1_d;
      m1_q   <= m1_d;
      v2_q   <= v2_d;
      p_ll_q <= p_ll_d;
      p_lh_q <= p_lh_d;
      p_hl_q <= p_hl_d;
      p_hh_q <= p_hh_d;
      v3_q   <= v3_d;
      prod_q <= prod_d;
    end
  end

  assign in_ready  = en;
  assign out_valid = v3_q;
  assign out_prod  = prod_q;

`ifdef ACCA_ERR_STAT_EN
  logic [PW-1:0] exact2_q, exact2_d, exact3_q, exact3_d;
  logic [15:0]   err_cnt_q, err_cnt_d;

  // Exact product rides alongside the beat so it is compared only on transfer
  always_comb begin
    exact2_d  = exact2_q;
    exact3_d  = exact3_q;
    err_cnt_d = err_cnt_q;
    if (en) begin
      exact2_d = {{WIDTH{1'b0}}, a1_q} * {{WIDTH{1'b0}}, b1_q};
      exact3_d = exact2_q;
    end
    if (v3_q && out_ready && (prod_q != exact3_q) && (err_cnt_q != 16'hFFFF))
      err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exact2_q  <= '0;
      exact3_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      exact2_q  <= exact2_d;
      exact3_q  <= exact3_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_acca_mul_pipe.sv
// Self-checking bench for acca_mul_pipe: directed steps plus random traffic
// scored against an arithmetic model of the quadrant-split multiplier.
module tb_acca_mul_pipe;

  localparam int         WIDTH       = 8;
  localparam int         TRUNC       = 2;
  localparam logic [3:0] APPROX_MASK = 4'b1111;
  localparam int         H           = WIDTH / 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_a;
  logic [WIDTH-1:0]  in_b;
  logic              approx_en;
  logic              out_valid;
  logic              out_ready;
  logic [2*WIDTH-1:0] out_prod;
  logic [15:0]       err_cnt;

  typedef struct {
    logic [2*WIDTH-1:0] prod;
    logic               inexact;
    int                 cyc;
  } beat_t;

  beat_t              sb[$];
  int                 nChecks = 0;
  int                 nFails  = 0;
  int                 cycle   = 0;
  logic [15:0]        errModel = 16'h0;
  logic               strictLat = 1'b0;
  logic               checkReady = 1'b0;
  logic               lastAccepted = 1'b0;
  logic               prevStalled = 1'b0;
  logic [2*WIDTH-1:0] heldProd = '0;

  acca_mul_pipe #(.WIDTH(WIDTH), .TRUNC(TRUNC), .APPROX_MASK(APPROX_MASK)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .approx_en(approx_en), .out_valid(out_valid),
    .out_ready(out_ready), .out_prod(out_prod), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Product by the quadrant rules, using plain integer arithmetic
  function automatic logic [2*WIDTH-1:0] modelProd(input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b,
                                                   input logic ae);
    longint half, aL, aH, bL, bH, gran;
    longint p[4];
    half = longint'(1) << H;
    gran = longint'(1) << TRUNC;
    aL = a % half; aH = a / half;
    bL = b % half; bH = b / half;
    p[0] = aL * bL; p[1] = aL * bH; p[2] = aH * bL; p[3] = aH * bH;
    for (int q = 0; q < 4; q++)
      if (ae && APPROX_MASK[q]) p[q] = (p[q] / gran) * gran;
    return (2*WIDTH)'(p[0] + (p[1] + p[2]) * half + p[3] * half * half);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nChecks++;
    assert (observed === expected) else begin
      nFails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One clock: sample mid-cycle, score transfers, advance, then check err_cnt
  task automatic tick();
    logic incPending;
    beat_t e;
    incPending = 1'b0;
    lastAccepted = 1'b0;
    #1;
    if (rst_n) begin
      if (checkReady)
        checkOutput("bp_in_ready", in_ready,
                    !(!out_ready && sb.size() > 0 && (cycle - sb[0].cyc) >= 3));
      if (prevStalled) checkOutput("hold_prod", out_prod, heldProd);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checkOutput("spurious_out", out_valid, 1'b0);
        end else begin
          e = sb.pop_front();
          checkOutput("prod", out_prod, e.prod);
          if (strictLat) checkOutput("latency", cycle - e.cyc, 3);
          incPending = e.inexact;
        end
      end
      if (in_valid && in_ready) begin
        e.prod    = modelProd(in_a, in_b, approx_en);
        e.inexact = (e.prod != (2*WIDTH)'(in_a * in_b));
        e.cyc     = cycle;
        sb.push_back(e);
        lastAccepted = 1'b1;
      end
      prevStalled = out_valid && !out_ready;
      heldProd    = out_prod;
    end
    @(posedge clk);
    #1;
    cycle++;
    if (!rst_n) begin
      sb.delete();
      errModel    = 16'h0;
      prevStalled = 1'b0;
    end else if (incPending && errModel != 16'hFFFF) begin
      errModel = errModel + 16'd1;
    end
`ifdef ACCA_ERR_STAT_EN
    checkOutput("err_cnt", err_cnt, errModel);
`else
    checkOutput("err_cnt", err_cnt, 16'h0000);
`endif
  endtask

  task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b, input logic ae,
                               input logic ordy);
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    approx_en = ae;
    out_ready = ordy;
    tick();
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (sb.size() > 0 && budget < 40) begin
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
      budget++;
    end
    checkOutput("drain_empty", sb.size(), 0);
  endtask

  initial begin
    int sent, budget;
    logic [WIDTH-1:0] ra, rb;
    logic rae;

    // Reset then idle
    rst_n = 1'b0;
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    rst_n = 1'b1;
    checkOutput("rst_out_valid", out_valid, 1'b0);
    checkOutput("rst_out_prod", out_prod, 16'h0000);
    checkOutput("rst_err_cnt", err_cnt, 16'h0000);
    checkOutput("rst_in_ready", in_ready, 1'b1);

    // 0xFF x 0xFF approximate, then exact, with strict latency
    strictLat = 1'b1;
    applyStimulus(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    checkOutput("ff_approx_valid", out_valid, 1'b1);
    checkOutput("ff_approx_prod", out_prod, 16'hFCE0);
    applyStimulus(1'b1, 8'hFF, 8'hFF, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    checkOutput("ff_exact_prod", out_prod, 16'hFE01);
    drain();

    // Back-to-back mixed modes
    applyStimulus(1'b1, 8'd3, 8'd5, 1'b1, 1'b1);
    applyStimulus(1'b1, 8'd3, 8'd5, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'd16, 8'd16, 1'b1, 1'b1);
    checkOutput("b2b_0", out_prod, 16'd12);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    checkOutput("b2b_1", out_prod, 16'd15);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    checkOutput("b2b_2", out_prod, modelProd(8'd16, 8'd16, 1'b1));
    drain();
    strictLat = 1'b0;

    // Backpressure: 4 beats streaming while out_ready is held low for 5 cycles
    checkReady = 1'b1;
    sent = 0;
    for (int c = 0; c < 5; c++) begin
      ra = 8'($urandom); rb = 8'($urandom); rae = 1'($urandom);
      applyStimulus(sent < 4, ra, rb, rae, 1'b0);
      if (lastAccepted) sent++;
    end
    checkOutput("bp_in_ready_low", in_ready, 1'b0);
    budget = 0;
    while (sent < 4 && budget < 20) begin
      ra = 8'($urandom); rb = 8'($urandom); rae = 1'($urandom);
      applyStimulus(1'b1, ra, rb, rae, 1'b1);
      if (lastAccepted) sent++;
      budget++;
    end
    checkOutput("bp_all_sent", sent, 4);
    checkReady = 1'b0;
    drain();

    // Random traffic with random backpressure
    for (int c = 0; c < 300; c++) begin
      ra = 8'($urandom); rb = 8'($urandom); rae = 1'($urandom);
      applyStimulus(1'($urandom), ra, rb, rae, ($urandom_range(0, 3) != 0));
    end
    drain();

    // Mid-stream reset with three beats in flight
    applyStimulus(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1);
    applyStimulus(1'b1, 8'hA5, 8'h3C, 1'b1, 1'b1);
    applyStimulus(1'b1, 8'h77, 8'h99, 1'b0, 1'b1);
    rst_n = 1'b0;
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    rst_n = 1'b1;
    checkOutput("mid_rst_valid", out_valid, 1'b0);
    checkOutput("mid_rst_err", err_cnt, 16'h0000);
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
      checkOutput("mid_rst_no_stale", out_valid, 1'b0);
    end

    $display("[TB] directed and random phases complete");
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
